// File: rtl/if_row_sender.sv
// Row sender: reads one row of pixels from the IF buffer SRAM and forwards
// them to the IF scratchpad through a 2-entry skid FIFO with valid/ready.
module if_row_sender #(
  parameter int DWd     = 16,
  parameter int ConfDWd = 4,
  parameter int AddrWd  = 10
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic [ConfDWd-1:0] i_IFLen,
  input  logic [AddrWd-1:0]  i_base_addr,
  output logic               o_sram_ce,
  output logic [AddrWd-1:0]  o_sram_addr,
  input  logic [DWd-1:0]     i_sram_rdata,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  output logic [DWd-1:0]     o_pix_data,
  output logic               o_pix_zero,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             r_state;
  logic [ConfDWd-1:0] r_len, r_issued, r_popped;
  logic [AddrWd-1:0]  r_base, r_addr;
  logic               r_inflight;
  logic               r_done;
  logic [DWd-1:0]     r_mem [2];
  logic               r_wptr, r_rptr;
  logic [1:0]         r_cnt;

  logic               w_pop, w_issue;
  logic [2:0]         w_occ;
  logic [AddrWd-1:0]  w_cur_addr;

  assign w_pop      = (r_cnt != 2'd0) && i_pix_ready;
  // Occupancy after this cycle's pop: buffered plus the read still in flight.
  assign w_occ      = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_cur_addr = r_base + AddrWd'(r_issued);
  assign w_issue    = (r_state == RUN) && !i_stall && !i_reset &&
                      (r_issued != r_len) && (w_occ < 3'd2);

  assign o_sram_ce   = w_issue;
  assign o_sram_addr = w_issue ? w_cur_addr : r_addr;
  assign o_pix_valid = (r_cnt != 2'd0);
  assign o_pix_data  = r_mem[r_rptr];
  assign o_pix_zero  = (o_pix_data == '0);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_addr <= '0;
    end else if (w_issue) begin
      r_addr <= w_cur_addr;
    end
  end

  // Data returned one cycle after the read; a flush drops it on the floor.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_inflight <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
    end else if (i_reset) begin
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (r_inflight) begin
        r_mem[r_wptr] <= i_sram_rdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_base   <= '0;
      r_issued <= '0;
      r_popped <= '0;
      r_done   <= 1'b0;
    end else if (i_reset) begin
      r_state  <= IDLE;
      r_issued <= '0;
      r_popped <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_IFLen == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state  <= RUN;
              r_len    <= i_IFLen;
              r_base   <= i_base_addr;
              r_issued <= '0;
              r_popped <= '0;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_issued <= r_issued + ConfDWd'(1);
            if (r_issued + ConfDWd'(1) == r_len) r_state <= DRAIN;
          end
          if (w_pop) r_popped <= r_popped + ConfDWd'(1);
        end
        DRAIN: begin
          if (w_pop) begin
            r_popped <= r_popped + ConfDWd'(1);
            if (r_popped + ConfDWd'(1) == r_len) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/if_row_sender.md
IF_ROW_SENDER -- requirements
Module: if_row_sender

Interface
REQ-001 SHALL have parameter DWd, default 16, pixel data width.
REQ-002 SHALL have parameter ConfDWd, default 4, width of the row-length configuration.
REQ-003 SHALL have parameter AddrWd, default 10, IF buffer SRAM address width.
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  begin one row transfer; sampled only in IDLE.
REQ-007 SHALL have port i_reset  input  1  synchronous flush to IDLE.
REQ-008 SHALL have port i_stall  input  1  suppresses new SRAM reads while high.
REQ-009 SHALL have port i_IFLen  input  ConfDWd  pixels per row (RxPch); 0 is legal.
REQ-010 SHALL have port i_base_addr  input  AddrWd  SRAM address of first pixel.
REQ-011 SHALL have port o_sram_ce  output  1  SRAM read enable.
REQ-012 SHALL have port o_sram_addr  output  AddrWd  SRAM read address.
REQ-013 SHALL have port i_sram_rdata  input  DWd  SRAM read data, valid one cycle after o_sram_ce.
REQ-014 SHALL have port o_pix_valid  output  1  pixel available to IF scratchpad.
REQ-015 SHALL have port i_pix_ready  input  1  IF scratchpad accepts pixel.
REQ-016 SHALL have port o_pix_data  output  DWd  pixel value.
REQ-017 SHALL have port o_pix_zero  output  1  zero flag, high iff o_pix_data == 0.
REQ-018 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port o_done  output  1  one-cycle pulse at row completion.

Function
REQ-020 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on i_start with i_IFLen!=0, latching i_IFLen and i_base_addr.
REQ-021 SHALL, on i_start with i_IFLen==0 in IDLE, stay IDLE, issue no read, and pulse o_done the next cycle.
REQ-022 SHALL ignore i_start outside IDLE; latched length/base unaffected.
REQ-023 SHALL in RUN issue read k (k=0..len-1) at address (base+k) mod 2^AddrWd, wrapping silently.
REQ-024 SHALL issue a read in a cycle only if !i_stall, issued<len, and (fifo_count + inflight - pop) < 2.
REQ-025 SHALL buffer returned data in a 2-entry FIFO; o_pix_valid = FIFO non-empty; o_pix_data/o_pix_zero from FIFO head.
REQ-026 SHALL transfer a pixel when o_pix_valid && i_pix_ready; pop same edge.
REQ-027 SHALL hold o_pix_valid, o_pix_data, o_pix_zero stable while o_pix_valid && !i_pix_ready.
REQ-028 SHALL accept simultaneous push and pop in one cycle with count unchanged; FIFO SHALL never overflow.
REQ-029 SHALL go RUN->DRAIN once issued==len; DRAIN->IDLE on transfer of pixel len-1, pulsing o_done that cycle+1.
REQ-030 SHALL achieve first o_pix_valid 3 cycles after i_start (start cycle 0, read cycle 1, valid cycle 3) with no stall.
REQ-031 SHALL sustain one pixel per cycle when i_pix_ready stays high and i_stall low.
REQ-032 SHALL on i_reset return to IDLE next cycle, empty FIFO, discard in-flight read data, deassert o_pix_valid, no o_done; i_reset dominates i_start.
REQ-033 SHALL keep o_sram_addr at its last value when o_sram_ce is low.

Reset
REQ-034 SHALL, while i_rstn low, force IDLE, FIFO empty, counters 0, o_sram_ce=0, o_sram_addr=0, o_pix_valid=0, o_pix_data=0, o_pix_zero=1, o_busy=0, o_done=0.
REQ-035 SHALL, on i_rstn assertion mid-row, discard all transfer state; first row after release requires new i_start.

Verification
REQ-036 SHALL verify: len=4, base=0x010, data 5,0,7,9, ready=1 -> reads 0x010..0x013 cycles 1-4, valid cycles 3-6, zero flag only on 2nd pixel, o_done cycle 7.
REQ-037 SHALL verify: len=5, ready low cycles 3-8 -> at most 2 reads outstanding+buffered, data held stable, all 5 delivered in order.
REQ-038 SHALL verify: base=0x3FE, len=4 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-039 SHALL verify: i_IFLen=0 start -> no o_sram_ce, o_done one cycle later, o_busy stays 0.
REQ-040 SHALL verify: i_stall high 3 cycles mid-row -> no reads during stall, row completes intact; i_reset mid-row -> IDLE next cycle, o_pix_valid 0, no o_done.
